// File: rtl/pico_sequencer_if.sv
// Control bundle between the pico decoder / I/O ports and the sequencer.
// Decoder flags and I/O handshake inputs flow toward the sequencer.
// Strobes flow back toward the datapath and I/O ports.
//
// Handshake semantics:
//   in_valid / in_ack : the input port raises in_valid when it holds data.
//                       The sequencer pulses in_ack for exactly one cycle on
//                       the cycle it consumes that data. in_ack is never
//                       raised while in_valid is low.
//   out_valid / out_ready : the sequencer raises out_valid and holds it until
//                       accepted. A transfer happens on the cycle where
//                       out_valid & out_ready are both high. out_valid drops
//                       on the following cycle.
interface pico_sequencer_if;
  // Decoder flags
  logic reg_write;
  logic pc_rel_branch;
  logic mult;
  logic read_in;
  logic write_out;
  // I/O handshake inputs
  logic in_valid;
  logic out_ready;
  // Strobes
  logic ir_load;
  logic pc_en;
  logic pc_branch;
  logic reg_we;
  logic mult_start;
  logic in_ack;
  logic out_valid;

  // Core side: decoder and I/O ports drive flags and consume strobes.
  modport master (
    output reg_write, pc_rel_branch, mult, read_in, write_out,
    output in_valid, out_ready,
    input  ir_load, pc_en, pc_branch, reg_we, mult_start, in_ack, out_valid
  );

  // Sequencer side.
  modport slave (
    input  reg_write, pc_rel_branch, mult, read_in, write_out,
    input  in_valid, out_ready,
    output ir_load, pc_en, pc_branch, reg_we, mult_start, in_ack, out_valid
  );
endinterface

// File: rtl/pico_sequencer.sv
// Multi-cycle control sequencer for the pico MIPS core.
// Steps FETCH -> EXEC and stalls in MULT_WAIT, IN_WAIT or OUT_WAIT.
// State, multiplier counter and retired-instruction counter are registered.
// All strobes decode combinationally from the current state and inputs.
module pico_sequencer #(
  parameter int MULT_CYCLES = 4,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  pico_sequencer_if.slave    bus,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  // The counter is loaded with MULT_CYCLES-1 and counts down to zero.
  // One bit is enough when MULT_CYCLES is 1 (the load value is 0).
  localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_EXEC      = 3'd1,
    S_MULT_WAIT = 3'd2,
    S_IN_WAIT   = 3'd3,
    S_OUT_WAIT  = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic ir_load;
  logic pc_en;
  logic pc_branch;
  logic reg_we;
  logic mult_start;
  logic in_ack;
  logic out_valid;

  // Next-state and strobe decode. Reset masks every strobe in the same cycle,
  // so a stall that is interrupted never writes, acks or retires.
  always_comb begin
    state_d    = S_FETCH;
    cnt_d      = cnt_q;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    pc_branch  = 1'b0;
    reg_we     = 1'b0;
    mult_start = 1'b0;
    in_ack     = 1'b0;
    out_valid  = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_EXEC;
      end

      // Decoder flags are only looked at here; priority mult > read_in > write_out.
      S_EXEC: begin
        if (bus.mult) begin
          mult_start = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = S_MULT_WAIT;
        end else if (bus.read_in) begin
          if (bus.in_valid) begin
            reg_we  = 1'b1;
            in_ack  = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_IN_WAIT;
          end
        end else if (bus.write_out) begin
          out_valid = 1'b1;
          if (bus.out_ready) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_OUT_WAIT;
          end
        end else begin
          // ALU, branch, jump, or an unknown opcode (all flags low -> NOP).
          reg_we    = bus.reg_write;
          pc_en     = 1'b1;
          pc_branch = bus.pc_rel_branch;
          state_d   = S_FETCH;
        end
      end

      S_MULT_WAIT: begin
        if (cnt_q == '0) begin
          reg_we  = 1'b1;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = S_MULT_WAIT;
        end
      end

      S_IN_WAIT: begin
        if (bus.in_valid) begin
          reg_we  = 1'b1;
          in_ack  = 1'b1;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_IN_WAIT;
        end
      end

      S_OUT_WAIT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_OUT_WAIT;
        end
      end

      // Unused encodings fall back to FETCH on the next edge.
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (reset) begin
      ir_load    = 1'b0;
      pc_en      = 1'b0;
      pc_branch  = 1'b0;
      reg_we     = 1'b0;
      mult_start = 1'b0;
      in_ack     = 1'b0;
      out_valid  = 1'b0;
    end
  end

  // State, multiplier countdown and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      cnt_q       <= '0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_en) begin
        instr_count <= instr_count + COUNT_W'(1);
      end
    end
  end

  assign state          = state_q;
  assign bus.ir_load    = ir_load;
  assign bus.pc_en      = pc_en;
  assign bus.pc_branch  = pc_branch;
  assign bus.reg_we     = reg_we;
  assign bus.mult_start = mult_start;
  assign bus.in_ack     = in_ack;
  assign bus.out_valid  = out_valid;

endmodule

// File: tb/tb_pico_sequencer.sv
// Testbench for pico_sequencer. Two instances: default parameters, and a
// narrow one (MULT_CYCLES=1, COUNT_W=2) for the latency and wrap corners.
// Only one instance is active at a time; the other is held in reset.
module tb_pico_sequencer;

  localparam int MC0 = 4;
  localparam int CW0 = 16;
  localparam int MC1 = 1;
  localparam int CW1 = 2;

  // Expected outcome of one instruction, from its kind and wait counts.
  typedef struct packed {
    logic [7:0]  lat;        // cycles from ir_load to pc_en, inclusive
    logic        reg_we;
    logic        pc_branch;
    logic [2:0]  wait_st;    // state reported during stall cycles
    logic [7:0]  n_ovalid;   // cycles with out_valid high
    logic        n_mstart;   // mult_start pulses
    logic        n_ack;      // in_ack pulses
    logic [15:0] count;      // instr_count after retire
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0;
  logic rst1;
  logic sel;

  // ---------------- DUTs ----------------
  pico_sequencer_if b0();
  pico_sequencer_if b1();

  logic [2:0]     st0;
  logic [2:0]     st1;
  logic [CW0-1:0] ic0;
  logic [CW1-1:0] ic1;

  pico_sequencer #(.MULT_CYCLES(MC0), .COUNT_W(CW0)) dut0 (
    .clk(clk), .reset(rst0), .bus(b0), .state(st0), .instr_count(ic0)
  );
  pico_sequencer #(.MULT_CYCLES(MC1), .COUNT_W(CW1)) dut1 (
    .clk(clk), .reset(rst1), .bus(b1), .state(st1), .instr_count(ic1)
  );

  logic d_rw, d_br, d_mult, d_rin, d_wout, d_iv, d_ordy;

  assign b0.reg_write     = d_rw;
  assign b0.pc_rel_branch = d_br;
  assign b0.mult          = d_mult;
  assign b0.read_in       = d_rin;
  assign b0.write_out     = d_wout;
  assign b0.in_valid      = d_iv;
  assign b0.out_ready     = d_ordy;
  assign b1.reg_write     = d_rw;
  assign b1.pc_rel_branch = d_br;
  assign b1.mult          = d_mult;
  assign b1.read_in       = d_rin;
  assign b1.write_out     = d_wout;
  assign b1.in_valid      = d_iv;
  assign b1.out_ready     = d_ordy;

  // obs bits: 6 ir_load, 5 pc_en, 4 pc_branch, 3 reg_we, 2 mult_start, 1 in_ack, 0 out_valid
  logic [6:0]     obs0, obs1, obs;
  logic [2:0]     cst;
  logic [CW0-1:0] cic;
  logic           crst;

  assign obs0 = {b0.ir_load, b0.pc_en, b0.pc_branch, b0.reg_we, b0.mult_start, b0.in_ack, b0.out_valid};
  assign obs1 = {b1.ir_load, b1.pc_en, b1.pc_branch, b1.reg_we, b1.mult_start, b1.in_ack, b1.out_valid};
  assign obs  = sel ? obs1 : obs0;
  assign cst  = sel ? st1 : st0;
  assign cic  = sel ? {{(CW0-CW1){1'b0}}, ic1} : ic0;
  assign crst = sel ? rst1 : rst0;

  // ---------------- scoreboard state ----------------
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] f, input logic iv, input logic ordy);
    {d_rw, d_br, d_mult, d_rin, d_wout} = f;
    d_iv   = iv;
    d_ordy = ordy;
    tick();
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst1 = v;
    else     rst0 = v;
  endtask

  function automatic int cur_mc();
    return sel ? MC1 : MC0;
  endfunction

  function automatic int cur_mask();
    return sel ? ((1 << CW1) - 1) : ((1 << CW0) - 1);
  endfunction

  // kind: 0 ALU/branch/NOP, 1 MULT, 2 STIN, 3 LOUT.
  // k: number of cycles (starting at EXEC) the I/O port is not ready.
  task automatic issue(input int kind, input int k, input logic rw, input logic br);
    exp_t       e;
    int         lat;
    logic [4:0] fx;
    logic       iv, ordy;
    e  = '0;
    fx = {rw, br, 3'b000};
    case (kind)
      0: begin
        lat = 2;
        e.reg_we = rw;
        e.pc_branch = br;
      end
      1: begin
        lat = 2 + cur_mc();
        e.reg_we = 1'b1;
        e.wait_st = 3'd2;
        e.n_mstart = 1'b1;
        fx = {rw, br, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      end
      2: begin
        lat = 2 + k;
        e.reg_we = 1'b1;
        e.wait_st = 3'd3;
        e.n_ack = 1'b1;
        fx = {rw, br, 1'b0, 1'b1, 1'($urandom_range(0, 1))};
      end
      default: begin
        lat = 2 + k;
        e.wait_st = 3'd4;
        e.n_ovalid = 8'(k + 1);
        fx = {rw, br, 3'b001};
      end
    endcase
    model_cnt = (model_cnt + 1) & cur_mask();
    e.lat   = 8'(lat);
    e.count = 16'(model_cnt);
    exp_q.push_back(e);
    for (int i = 0; i < lat; i++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      if (kind == 2 && i >= 1) iv   = (i == lat - 1);
      if (kind == 3 && i >= 1) ordy = (i == lat - 1);
      // Outside EXEC the flags are noise the sequencer must ignore.
      drive((i == 1) ? fx : 5'($urandom), iv, ordy);
    end
  endtask

  // Start a MULT and hit reset during its stall; nothing may retire.
  task automatic reset_mid_mult();
    exp_t e;
    int   at;
    e = '0;
    e.lat = 8'(2 + cur_mc());
    e.reg_we = 1'b1;
    e.wait_st = 3'd2;
    e.n_mstart = 1'b1;
    exp_q.push_back(e);
    at = (cur_mc() >= 2) ? 3 : 2;
    for (int i = 0; i < at; i++) begin
      drive((i == 1) ? 5'b00100 : 5'b00000, 1'b0, 1'b0);
    end
    set_rst(1'b1);
    exp_q.delete();
    model_cnt = 0;
    drive(5'b10100, 1'b1, 1'b1);
    set_rst(1'b0);
  endtask

  // Let the last retire's count settle, then park the active DUT in reset.
  task automatic finish_phase();
    @(negedge clk);
    #1;
    set_rst(1'b1);
    {d_rw, d_br, d_mult, d_rin, d_wout, d_iv, d_ordy} = '0;
    tick();
    tick();
  endtask

  // ---------------- monitor ----------------
  exp_t cur;
  bit   in_flight = 1'b0;
  bit   cnt_pend = 1'b0;
  bit   post_rst = 1'b0;
  int   pend_val = 0;
  int   cyc = 0, nms = 0, ms_cyc = 0, nack = 0, nov = 0, nwe = 0;
  int   exp_st;

  always @(negedge clk) begin
    if (crst) begin
      check("reset_strobes", int'(obs), 0);
      in_flight = 1'b0;
      cnt_pend  = 1'b0;
      post_rst  = 1'b1;
    end else begin
      if (post_rst) begin
        check("post_reset_state", int'(cst), 0);
        check("post_reset_count", int'(cic), 0);
        post_rst = 1'b0;
      end
      if (cnt_pend) begin
        check("instr_count", int'(cic), pend_val);
        cnt_pend = 1'b0;
      end
      if (obs[6]) begin
        if (in_flight) check("ir_load_mid_instr", 1, 0);
        if (exp_q.size() > 0) begin
          cur = exp_q[0];
          in_flight = 1'b1;
          cyc = 0; nms = 0; ms_cyc = -1; nack = 0; nov = 0; nwe = 0;
        end else begin
          in_flight = 1'b0;
        end
      end
      if (in_flight) begin
        exp_st = (cyc == 0) ? 0 : (cyc == 1) ? 1 : int'(cur.wait_st);
        check("state", int'(cst), exp_st);
        nms  += int'(obs[2]);
        if (obs[2]) ms_cyc = cyc;
        nack += int'(obs[1]);
        nov  += int'(obs[0]);
        nwe  += int'(obs[3]);
        if (obs[5]) begin
          check("latency", cyc + 1, int'(cur.lat));
          check("reg_we_at_retire", int'(obs[3]), int'(cur.reg_we));
          check("reg_we_pulses", nwe, int'(cur.reg_we));
          check("pc_branch", int'(obs[4]), int'(cur.pc_branch));
          check("mult_start_pulses", nms, int'(cur.n_mstart));
          if (cur.n_mstart) check("mult_start_cycle", ms_cyc, 1);
          check("in_ack_pulses", nack, int'(cur.n_ack));
          check("in_ack_at_retire", int'(obs[1]), int'(cur.n_ack));
          check("out_valid_cycles", nov, int'(cur.n_ovalid));
          void'(exp_q.pop_front());
          in_flight = 1'b0;
          cnt_pend  = 1'b1;
          pend_val  = int'(cur.count);
        end else begin
          cyc++;
          if (cyc > 64) begin
            check("retire_timeout", cyc, int'(cur.lat));
            in_flight = 1'b0;
          end
        end
      end else begin
        check("idle_strobes", int'(obs[5:0]), 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    sel  = 1'b0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(5'b00000, 1'b0, 1'b0);
    drive(5'b00000, 1'b0, 1'b0);
    rst0 = 1'b0;

    // Directed sequence on the default instance.
    issue(0, 0, 1'b1, 1'b0);   // ADD
    issue(0, 0, 1'b0, 1'b1);   // BEQ taken
    issue(0, 0, 1'b0, 1'b1);   // JMP
    issue(1, 0, 1'b1, 1'b0);   // MULT
    issue(2, 3, 1'b0, 1'b0);   // STIN, 3 cycles without data
    issue(3, 2, 1'b0, 1'b0);   // LOUT, 2 cycles not ready
    issue(2, 0, 1'b1, 1'b1);   // STIN, data already there
    issue(3, 0, 1'b1, 1'b1);   // LOUT, accepted at once
    reset_mid_mult();
    issue(0, 0, 1'b1, 1'b0);   // ADD after reset -> count 1
    issue(0, 0, 1'b0, 1'b0);   // NOP
    repeat (200) begin
      issue($urandom_range(0, 3), $urandom_range(0, 4),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    finish_phase();

    // Narrow instance: single-cycle multiplier and 2-bit counter.
    sel = 1'b1;
    model_cnt = 0;
    drive(5'b00000, 1'b0, 1'b0);
    rst1 = 1'b0;
    repeat (5) issue(0, 0, 1'b0, 1'b0);   // counts 1,2,3,0,1
    issue(1, 0, 1'b0, 1'b1);
    reset_mid_mult();
    repeat (100) begin
      issue($urandom_range(0, 3), $urandom_range(0, 4),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    finish_phase();

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
